// File: rtl/pa_risc_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pa_risc_pkg
// Purpose  : Shared constants and types for the PA-RISC pipeline front end.
//            Holds datapath widths, the NOP encoding, PC-queue step sizes,
//            the fetch-FSM state type and the opcode constants the decoder
//            already relies on.
// Revision : 1.0 - initial release
// ============================================================================
package pa_risc_pkg;

  // Datapath widths
  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  // Opcode field 000000 decodes as NOP, so an all-zero word is a bubble
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // PC queue increments and the BL return-address offset (skips the
  // branch and its delay slot)
  localparam int PC_STEP   = 4;
  localparam int RA_OFFSET = 8;

  // Major opcode field, instruction bits [31:26]
  localparam logic [5:0] OP_NOP   = 6'h00;
  localparam logic [5:0] OP_ARITH = 6'h02;
  localparam logic [5:0] OP_LDW   = 6'h12;
  localparam logic [5:0] OP_STW   = 6'h1A;
  localparam logic [5:0] OP_COMB  = 6'h20;
  localparam logic [5:0] OP_ADDIB = 6'h29;
  localparam logic [5:0] OP_ADDI  = 6'h2D;
  localparam logic [5:0] OP_BL    = 6'h3A;

  // Fetch redirect FSM: RUN = no deferred redirect, PEND = a branch target
  // was captured while the pipe was stalled and is waiting to be applied
  typedef enum logic [0:0] {
    FS_RUN  = 1'b0,
    FS_PEND = 1'b1
  } fetch_state_e;

endpackage : pa_risc_pkg
`default_nettype wire

// File: rtl/pa_risc_pc_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pa_risc_pc_queue
// Purpose  : PA-RISC PC front/back queue with one architectural delay slot,
//            plus the deferred-redirect FSM that remembers a branch target
//            arriving while the pipe is stalled.
// Ports    : clk           - pipeline clock
//            reset         - synchronous, active-low reset
//            le            - load enable; 0 holds the queue (stall)
//            br_taken      - EX-stage taken branch, one-cycle pulse
//            br_target     - branch target, valid with br_taken
//            pc_front      - address currently being fetched
//            pc_back       - next fetch address
//            redirect_pend - a stalled redirect is waiting to be applied
// Revision : 1.0 - initial release
// ============================================================================
module pa_risc_pc_queue #(
  parameter int              PC_W     = pa_risc_pkg::PC_W,
  parameter logic [PC_W-1:0] PC_RESET = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            le,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  output logic [PC_W-1:0] pc_front,
  output logic [PC_W-1:0] pc_back,
  output logic            redirect_pend
);

  import pa_risc_pkg::*;

  localparam logic [PC_W-1:0] C_STEP = PC_W'(PC_STEP);

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [PC_W-1:0] r_front;
  logic [PC_W-1:0] r_back;
  logic [PC_W-1:0] r_pend_tgt;
  logic [PC_W-1:0] w_front_nxt;
  logic [PC_W-1:0] w_back_nxt;
  logic [PC_W-1:0] w_pend_tgt_nxt;

  // State register. Reset also drops any captured target so a stale
  // redirect can never surface after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= FS_RUN;
      r_front    <= PC_RESET;
      r_back     <= PC_RESET + C_STEP;
      r_pend_tgt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_front    <= w_front_nxt;
      r_back     <= w_back_nxt;
      r_pend_tgt <= w_pend_tgt_nxt;
    end
  end

  // Next-state logic. On every advance the old back becomes the new front,
  // so the delay-slot instruction is always fetched; only the new back
  // differs between sequential flow and a redirect. A same-edge br_taken is
  // younger than a captured target and therefore wins.
  always_comb begin
    w_state_nxt    = r_state;
    w_front_nxt    = r_front;
    w_back_nxt     = r_back;
    w_pend_tgt_nxt = r_pend_tgt;

    case (r_state)
      FS_RUN: begin
        if (le) begin
          w_front_nxt = r_back;
          w_back_nxt  = br_taken ? br_target : (r_back + C_STEP);
        end else if (br_taken) begin
          w_state_nxt    = FS_PEND;
          w_pend_tgt_nxt = br_target;
        end
      end

      FS_PEND: begin
        if (le) begin
          w_front_nxt = r_back;
          w_back_nxt  = br_taken ? br_target : r_pend_tgt;
          w_state_nxt = FS_RUN;
        end else if (br_taken) begin
          // Still stalled: youngest redirect replaces the captured one
          w_pend_tgt_nxt = br_target;
        end
      end

      default: begin
        w_state_nxt = FS_RUN;
      end
    endcase
  end

  assign pc_front      = r_front;
  assign pc_back       = r_back;
  assign redirect_pend = (r_state == FS_PEND);

endmodule : pa_risc_pc_queue
`default_nettype wire

// File: rtl/pa_risc_fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pa_risc_fetch_stage
// Purpose  : Instruction-fetch stage and IF/ID pipeline register. Drives the
//            instruction memory from PC front, latches the returned word into
//            IF/ID and supports stall, EX redirect (including one arriving
//            during a stall) and delay-slot nullification.
// Ports    : clk            - pipeline clock
//            reset          - synchronous, active-low reset
//            LE             - load enable for PC queue and IF/ID (0 = stall)
//            br_taken       - EX-stage taken branch pulse
//            br_target      - branch target, valid with br_taken
//            nullify        - squash current IF/ID contents to NOP
//            imem_addr      - instruction-memory byte address (from PC front)
//            imem_data      - combinational instruction-memory read data
//            InstructionOut - IF/ID instruction register
//            PCFrontOut     - PC front (address being fetched)
//            PCBackOut      - PC back (next fetch address)
//            IF_PC          - PC of the instruction held in IF/ID
//            IF_RA          - BL return address for IF/ID (IF_PC + 8)
//            redirect_pend  - stalled redirect waiting to be applied
// Revision : 1.0 - initial release
// ============================================================================
module pa_risc_fetch_stage #(
  parameter int                 PC_W     = pa_risc_pkg::PC_W,
  parameter int                 INSTR_W  = pa_risc_pkg::INSTR_W,
  parameter int                 IMEM_AW  = 9,
  parameter logic [PC_W-1:0]    PC_RESET = '0,
  parameter logic [INSTR_W-1:0] NOP_WORD = INSTR_W'(pa_risc_pkg::NOP_WORD)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               LE,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_target,
  input  logic               nullify,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] InstructionOut,
  output logic [PC_W-1:0]    PCFrontOut,
  output logic [PC_W-1:0]    PCBackOut,
  output logic [PC_W-1:0]    IF_PC,
  output logic [PC_W-1:0]    IF_RA,
  output logic               redirect_pend
);

  import pa_risc_pkg::*;

  localparam logic [PC_W-1:0] C_RA_OFFSET = PC_W'(RA_OFFSET);

  logic [PC_W-1:0]    w_front;
  logic [PC_W-1:0]    w_back;
  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_if_pc;
  logic [PC_W-1:0]    r_if_ra;

  pa_risc_pc_queue #(
    .PC_W     (PC_W),
    .PC_RESET (PC_RESET)
  ) u_pc_queue (
    .clk           (clk),
    .reset         (reset),
    .le            (LE),
    .br_taken      (br_taken),
    .br_target     (br_target),
    .pc_front      (w_front),
    .pc_back       (w_back),
    .redirect_pend (redirect_pend)
  );

  // Instruction memory is byte addressed by the low bits of PC front; a
  // memory wider than the PC is zero-extended.
  generate
    if (IMEM_AW <= PC_W) begin : g_imem_addr_slice
      assign imem_addr = w_front[IMEM_AW-1:0];
    end else begin : g_imem_addr_zext
      assign imem_addr = {{(IMEM_AW-PC_W){1'b0}}, w_front};
    end
  endgenerate

  // IF/ID register. Nullify only replaces the instruction word: on an
  // advance IF_PC/IF_RA still follow the fetched slot, and during a stall
  // the squash is applied without disturbing the held PC.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_instr <= NOP_WORD;
      r_if_pc <= '0;
      r_if_ra <= C_RA_OFFSET;
    end else if (LE) begin
      r_instr <= nullify ? NOP_WORD : imem_data;
      r_if_pc <= w_front;
      r_if_ra <= w_front + C_RA_OFFSET;
    end else if (nullify) begin
      r_instr <= NOP_WORD;
    end
  end

  assign InstructionOut = r_instr;
  assign PCFrontOut     = w_front;
  assign PCBackOut      = w_back;
  assign IF_PC          = r_if_pc;
  assign IF_RA          = r_if_ra;

endmodule : pa_risc_fetch_stage
`default_nettype wire

// File: tb/tb_pa_risc_fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pa_risc_fetch_stage
// Purpose  : Self-checking bench for pa_risc_fetch_stage. Directed scenarios
//            plus a randomized run compared against a cycle-level model of
//            the fetch rules (PC queue, deferred redirect, IF/ID, nullify).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pa_risc_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        LE;
  logic        br_taken;
  logic [31:0] br_target;
  logic        nullify;
  logic [8:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] InstructionOut;
  logic [31:0] PCFrontOut;
  logic [31:0] PCBackOut;
  logic [31:0] IF_PC;
  logic [31:0] IF_RA;
  logic        redirect_pend;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  logic [31:0] m_front, m_back, m_pend_tgt, m_instr, m_ifpc, m_ifra;
  bit          m_pend;

  always #5 clk = ~clk;

  // Address-derived memory contents so every fetched word is identifiable
  function automatic logic [31:0] mem_word(input logic [8:0] a);
    return {a[7:0], 8'hA5, 7'h00, a};
  endfunction

  assign imem_data = mem_word(imem_addr);

  pa_risc_fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .LE             (LE),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .nullify        (nullify),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .InstructionOut (InstructionOut),
    .PCFrontOut     (PCFrontOut),
    .PCBackOut      (PCBackOut),
    .IF_PC          (IF_PC),
    .IF_RA          (IF_RA),
    .redirect_pend  (redirect_pend)
  );

  // One clock edge: drive inputs, advance the reference model, settle
  task automatic cyc(input bit rst_n, input bit le, input bit br,
                     input logic [31:0] tgt, input bit nul);
    logic [31:0] nb;
    reset = rst_n; LE = le; br_taken = br; br_target = tgt; nullify = nul;
    @(posedge clk);
    if (!rst_n) begin
      m_front = 32'h0; m_back = 32'h4; m_pend = 1'b0; m_pend_tgt = 32'h0;
      m_instr = 32'h0; m_ifpc = 32'h0; m_ifra = 32'h8;
    end else if (le) begin
      m_instr = nul ? 32'h0 : mem_word(m_front[8:0]);
      m_ifpc  = m_front;
      m_ifra  = m_front + 32'd8;
      nb      = br ? tgt : (m_pend ? m_pend_tgt : m_back + 32'd4);
      m_front = m_back;
      m_back  = nb;
      m_pend  = 1'b0;
    end else begin
      if (nul) m_instr = 32'h0;
      if (br) begin m_pend = 1'b1; m_pend_tgt = tgt; end
    end
    #1;
    br_taken = 1'b0; nullify = 1'b0;
  endtask

  task automatic test_reset();
    cyc(0, 1, 1, 32'h1234, 1);
    n_checks++; if (PCFrontOut !== 32'h0) begin n_fail++; $display("FAIL rst_front got=%h exp=%h", PCFrontOut, 32'h0); end
    n_checks++; if (PCBackOut !== 32'h4) begin n_fail++; $display("FAIL rst_back got=%h exp=%h", PCBackOut, 32'h4); end
    n_checks++; if (InstructionOut !== 32'h0) begin n_fail++; $display("FAIL rst_instr got=%h exp=%h", InstructionOut, 32'h0); end
    n_checks++; if (IF_PC !== 32'h0) begin n_fail++; $display("FAIL rst_ifpc got=%h exp=%h", IF_PC, 32'h0); end
    n_checks++; if (IF_RA !== 32'h8) begin n_fail++; $display("FAIL rst_ifra got=%h exp=%h", IF_RA, 32'h8); end
    n_checks++; if (redirect_pend !== 1'b0) begin n_fail++; $display("FAIL rst_pend got=%b exp=0", redirect_pend); end
    n_checks++; if (imem_addr !== 9'h0) begin n_fail++; $display("FAIL rst_imem_addr got=%h exp=0", imem_addr); end
  endtask

  task automatic test_sequential();
    logic [31:0] e;
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 0, 0, 0);
      e = 32'(4 * i);
      n_checks++; if (PCFrontOut !== e + 32'd4) begin n_fail++; $display("FAIL seq_front[%0d] got=%h exp=%h", i, PCFrontOut, e + 32'd4); end
      n_checks++; if (InstructionOut !== mem_word(e[8:0])) begin n_fail++; $display("FAIL seq_instr[%0d] got=%h exp=%h", i, InstructionOut, mem_word(e[8:0])); end
      n_checks++; if (IF_PC !== e) begin n_fail++; $display("FAIL seq_ifpc[%0d] got=%h exp=%h", i, IF_PC, e); end
      n_checks++; if (IF_RA !== e + 32'd8) begin n_fail++; $display("FAIL seq_ifra[%0d] got=%h exp=%h", i, IF_RA, e + 32'd8); end
    end
  endtask

  task automatic test_branch();
    cyc(0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 32'h40, 0);
    n_checks++; if (PCFrontOut !== 32'hC) begin n_fail++; $display("FAIL br_front got=%h exp=%h", PCFrontOut, 32'hC); end
    n_checks++; if (PCBackOut !== 32'h40) begin n_fail++; $display("FAIL br_back got=%h exp=%h", PCBackOut, 32'h40); end
    n_checks++; if (InstructionOut !== mem_word(9'h8)) begin n_fail++; $display("FAIL br_instr0 got=%h exp=%h", InstructionOut, mem_word(9'h8)); end
    cyc(1, 1, 0, 0, 0);
    n_checks++; if (InstructionOut !== mem_word(9'hC)) begin n_fail++; $display("FAIL br_slot got=%h exp=%h", InstructionOut, mem_word(9'hC)); end
    n_checks++; if (PCFrontOut !== 32'h40 || PCBackOut !== 32'h44) begin n_fail++; $display("FAIL br_queue got=%h/%h exp=40/44", PCFrontOut, PCBackOut); end
    cyc(1, 1, 0, 0, 0);
    n_checks++; if (InstructionOut !== mem_word(9'h40)) begin n_fail++; $display("FAIL br_target_instr got=%h exp=%h", InstructionOut, mem_word(9'h40)); end
    n_checks++; if (IF_PC !== 32'h40) begin n_fail++; $display("FAIL br_target_ifpc got=%h exp=%h", IF_PC, 32'h40); end
  endtask

  task automatic test_stall_redirect();
    cyc(0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 32'h80, 0);
    n_checks++; if (redirect_pend !== 1'b1) begin n_fail++; $display("FAIL stall_pend got=%b exp=1", redirect_pend); end
    cyc(1, 0, 0, 0, 0);
    n_checks++; if (PCFrontOut !== 32'h8 || PCBackOut !== 32'hC) begin n_fail++; $display("FAIL stall_hold_pc got=%h/%h exp=8/c", PCFrontOut, PCBackOut); end
    n_checks++; if (InstructionOut !== mem_word(9'h4) || IF_PC !== 32'h4) begin n_fail++; $display("FAIL stall_hold_ifid got=%h/%h exp=%h/4", InstructionOut, IF_PC, mem_word(9'h4)); end
    n_checks++; if (redirect_pend !== 1'b1) begin n_fail++; $display("FAIL stall_pend_hold got=%b exp=1", redirect_pend); end
    cyc(1, 1, 0, 0, 0);
    n_checks++; if (PCBackOut !== 32'h80 || PCFrontOut !== 32'hC) begin n_fail++; $display("FAIL stall_apply got=%h/%h exp=c/80", PCFrontOut, PCBackOut); end
    n_checks++; if (redirect_pend !== 1'b0) begin n_fail++; $display("FAIL stall_pend_clr got=%b exp=0", redirect_pend); end
    cyc(1, 1, 0, 0, 0);
    n_checks++; if (PCFrontOut !== 32'h80) begin n_fail++; $display("FAIL stall_front got=%h exp=80", PCFrontOut); end
  endtask

  task automatic test_nullify();
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 0);
    n_checks++; if (IF_PC !== 32'h10) begin n_fail++; $display("FAIL nul_setup got=%h exp=10", IF_PC); end
    cyc(1, 1, 0, 0, 1);
    n_checks++; if (InstructionOut !== 32'h0) begin n_fail++; $display("FAIL nul_instr got=%h exp=0", InstructionOut); end
    n_checks++; if (IF_PC !== 32'h14) begin n_fail++; $display("FAIL nul_ifpc got=%h exp=14", IF_PC); end
    cyc(1, 1, 0, 0, 0);
    n_checks++; if (InstructionOut !== mem_word(9'h18)) begin n_fail++; $display("FAIL nul_resume got=%h exp=%h", InstructionOut, mem_word(9'h18)); end
    cyc(1, 0, 0, 0, 1);
    n_checks++; if (InstructionOut !== 32'h0) begin n_fail++; $display("FAIL nul_stall_instr got=%h exp=0", InstructionOut); end
    n_checks++; if (IF_PC !== 32'h18 || PCFrontOut !== 32'h1C) begin n_fail++; $display("FAIL nul_stall_hold got=%h/%h exp=18/1c", IF_PC, PCFrontOut); end
  endtask

  task automatic test_wrap();
    cyc(0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 32'hFFFF_FFF8, 0);
    cyc(1, 1, 0, 0, 0);
    n_checks++; if (PCFrontOut !== 32'hFFFF_FFF8 || PCBackOut !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_setup got=%h/%h exp=fffffff8/fffffffc", PCFrontOut, PCBackOut); end
    cyc(1, 1, 0, 0, 0);
    n_checks++; if (PCBackOut !== 32'h0) begin n_fail++; $display("FAIL wrap_back0 got=%h exp=0", PCBackOut); end
    cyc(1, 1, 0, 0, 0);
    n_checks++; if (PCBackOut !== 32'h4) begin n_fail++; $display("FAIL wrap_back4 got=%h exp=4", PCBackOut); end
    n_checks++; if (IF_PC !== 32'hFFFF_FFFC || IF_RA !== 32'h4) begin n_fail++; $display("FAIL wrap_ifra got=%h/%h exp=fffffffc/4", IF_PC, IF_RA); end
  endtask

  task automatic test_reset_pending();
    cyc(0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 1, 32'h200, 0);
    n_checks++; if (redirect_pend !== 1'b1) begin n_fail++; $display("FAIL rp_pend got=%b exp=1", redirect_pend); end
    cyc(0, 1, 0, 0, 0);
    n_checks++; if (PCFrontOut !== 32'h0 || PCBackOut !== 32'h4) begin n_fail++; $display("FAIL rp_pc got=%h/%h exp=0/4", PCFrontOut, PCBackOut); end
    n_checks++; if (redirect_pend !== 1'b0 || InstructionOut !== 32'h0) begin n_fail++; $display("FAIL rp_clr got=%b/%h exp=0/0", redirect_pend, InstructionOut); end
    for (int i = 1; i <= 3; i++) begin
      cyc(1, 1, 0, 0, 0);
      n_checks++; if (PCBackOut !== 32'(4 * i + 4)) begin n_fail++; $display("FAIL rp_stale[%0d] got=%h exp=%h", i, PCBackOut, 32'(4 * i + 4)); end
    end
  endtask

  task automatic test_random();
    bit          r, l, b, n;
    logic [31:0] t;
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 59) != 0);
      l = ($urandom_range(0, 3) != 0);
      b = ($urandom_range(0, 4) == 0);
      n = ($urandom_range(0, 7) == 0);
      t = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_01FC);
      cyc(r, l, b, t, n);
      n_checks++; if (PCFrontOut !== m_front) begin n_fail++; $display("FAIL rnd_front[%0d] got=%h exp=%h", i, PCFrontOut, m_front); end
      n_checks++; if (PCBackOut !== m_back) begin n_fail++; $display("FAIL rnd_back[%0d] got=%h exp=%h", i, PCBackOut, m_back); end
      n_checks++; if (InstructionOut !== m_instr) begin n_fail++; $display("FAIL rnd_instr[%0d] got=%h exp=%h", i, InstructionOut, m_instr); end
      n_checks++; if (IF_PC !== m_ifpc) begin n_fail++; $display("FAIL rnd_ifpc[%0d] got=%h exp=%h", i, IF_PC, m_ifpc); end
      n_checks++; if (IF_RA !== m_ifra) begin n_fail++; $display("FAIL rnd_ifra[%0d] got=%h exp=%h", i, IF_RA, m_ifra); end
      n_checks++; if (redirect_pend !== m_pend) begin n_fail++; $display("FAIL rnd_pend[%0d] got=%b exp=%b", i, redirect_pend, m_pend); end
      n_checks++; if (imem_addr !== m_front[8:0]) begin n_fail++; $display("FAIL rnd_imem_addr[%0d] got=%h exp=%h", i, imem_addr, m_front[8:0]); end
    end
  endtask

  initial begin
    reset = 1'b0; LE = 1'b0; br_taken = 1'b0; br_target = 32'h0; nullify = 1'b0;
    test_reset();
    test_sequential();
    test_branch();
    test_stall_redirect();
    test_nullify();
    test_wrap();
    test_reset_pending();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pa_risc_fetch_stage
`default_nettype wire
